// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the fetch unit and the decoder: state encoding,
// word geometry and the branch offset conversion.
package busca_instrucao_pkg;

   localparam int LARGURA_INSTR = 32;
   localparam int BYTES_PALAVRA = 4;

   typedef enum logic {
      BUSCA = 1'b0,
      FIM   = 1'b1
   } estado_t;

   // Signed word offset -> signed byte offset, 32-bit two's complement.
   function automatic logic [31:0] offset_em_bytes(input logic [15:0] offset_palavras);
      return {{14{offset_palavras[15]}}, offset_palavras, 2'b00};
   endfunction

endpackage

// File: rtl/busca_instrucao_calculo_desvio.sv
// Branch target: the word after the branch plus the signed word offset,
// with 32-bit wrap-around.
module calculo_desvio
   import busca_instrucao_pkg::*;
(
   input  logic [31:0] pc_ir,
   input  logic [15:0] desvio_offset,
   output logic [31:0] alvo
);

   always_comb begin
      alvo = pc_ir + 32'(BYTES_PALAVRA) + offset_em_bytes(desvio_offset);
   end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: streams words from a combinational instruction
// memory into a one-deep ir register, follows taken branches, stops at end of memory.
module busca_instrucao
   import busca_instrucao_pkg::*;
#(
   parameter int          NUM_PALAVRAS = 32,
   parameter logic [31:0] PC_INICIAL   = 32'd0
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] endereco,
   input  logic [31:0] instrucao,
   output logic [31:0] ir,
   output logic [31:0] pc_ir,
   output logic        ir_valido,
   input  logic        ir_pronto,
   input  logic        desvio,
   input  logic [15:0] desvio_offset,
   output logic        terminou
);

   localparam logic [31:0] LIMITE = 32'(NUM_PALAVRAS * BYTES_PALAVRA);

   estado_t     estado_q, estado_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pc_ir_q, pc_ir_d;
   logic        ir_valido_q, ir_valido_d;
   logic        terminou_q, terminou_d;

   logic        aceite;
   logic        slot_busca;
   logic [31:0] alvo;

   calculo_desvio u_calculo_desvio (
      .pc_ir         (pc_ir_q),
      .desvio_offset (desvio_offset),
      .alvo          (alvo)
   );

   assign aceite     = ir_valido_q && ir_pronto;
   assign slot_busca = !ir_valido_q || aceite;

   // NOTE: every _d gets a hold default before the case, so no path leaves
   // a variable unassigned and no latch is inferred; blocking '=' is correct here.
   always_comb begin
      estado_d    = estado_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      pc_ir_d     = pc_ir_q;
      ir_valido_d = ir_valido_q;
      terminou_d  = terminou_q;

      case (estado_q)
         BUSCA: begin
            // A taken branch wins over the sequential fetch and over the
            // end-of-memory check; the target is range-checked on the next slot.
            if (aceite && desvio) begin
               pc_d        = alvo;
               ir_valido_d = 1'b0;
            end else if (slot_busca) begin
               if (pc_q < LIMITE) begin
                  ir_d        = instrucao;
                  pc_ir_d     = pc_q;
                  ir_valido_d = 1'b1;
                  pc_d        = pc_q + 32'(BYTES_PALAVRA);
               end else begin
                  estado_d    = FIM;
                  ir_valido_d = 1'b0;
                  terminou_d  = 1'b1;
               end
            end
         end
         FIM: begin
            ir_valido_d = 1'b0;
            terminou_d  = 1'b1;
         end
      endcase
   end

   // NOTE: reset is synchronous, so it sits inside the clocked block rather
   // than in the sensitivity list; state updates use non-blocking '<='.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q    <= BUSCA;
         pc_q        <= PC_INICIAL;
         ir_q        <= '0;
         pc_ir_q     <= '0;
         ir_valido_q <= 1'b0;
         terminou_q  <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         pc_ir_q     <= pc_ir_d;
         ir_valido_q <= ir_valido_d;
         terminou_q  <= terminou_d;
      end
   end

   assign endereco  = pc_q;
   assign ir        = ir_q;
   assign pc_ir     = pc_ir_q;
   assign ir_valido = ir_valido_q;
   assign terminou  = terminou_q;

endmodule
